// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_DATA_BITS  = 8;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
    return (^data ^ parity) == 1'b1;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, stability filter and falling-edge pulse for one
// raw PS/2 line. The filtered level only moves after FILTER_CYCLES
// consecutive synchronised samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // The current sample is the FILTER_CYCLES-th disagreeing one in a row.
  assign flip = (sync != level) && (cnt == CW'(FILTER_CYCLES - 1));

  // Synchronise, count disagreeing samples, move the level and flag 1->0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      fall <= flip && level;
      if (sync == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 keyboard receive front end: conditions the raw lines, deserialises
// 11-bit frames, checks odd parity and stop bit, aborts stalled frames.
// Optional build macro PS2_BREAK_FILTER_EN: swallow break sequences (F0 xx)
// so only make codes strobe out.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       frame_error,
  output logic       busy,
  output ps2_state_t debug_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          fall;
  logic          data_meta;
  logic          data_sync;

  ps2_state_t    state, state_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic          parity_bit, parity_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [7:0]    out_nxt;
  logic          key_nxt;
  logic          err_nxt;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending, break_nxt;
`endif

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clock (clock),
    .reset (reset),
    .line  (ps2_clk),
    .fall  (fall)
  );

  // Data only needs synchronising; it is stable around each clock fall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Frame FSM: next state, datapath updates and output strobes.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    bit_nxt    = bit_cnt;
    parity_nxt = parity_bit;
    out_nxt    = ps2_out;
    key_nxt    = 1'b0;
    err_nxt    = 1'b0;
    tmo_nxt    = (state == IDLE || fall) ? '0 : tmo_cnt + TW'(1);
`ifdef PS2_BREAK_FILTER_EN
    break_nxt  = break_pending;
`endif

    if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stalled frame: drop whatever was collected.
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      shift_nxt = '0;
      bit_nxt   = '0;
      tmo_nxt   = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          // A high start bit is a false start and is ignored silently.
          if (!data_sync) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            shift_nxt = '0;
          end
        end
        DATA: begin
          shift_nxt = {data_sync, shift_reg[7:1]};
          bit_nxt   = bit_cnt + 4'd1;
          if (bit_cnt == 4'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
        end
        PARITY: begin
          parity_nxt = data_sync;
          state_nxt  = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (data_sync && ps2_parity_ok(shift_reg, parity_bit)) begin
`ifdef PS2_BREAK_FILTER_EN
            if (break_pending) begin
              break_nxt = 1'b0;
            end else if (shift_reg == PS2_BREAK_CODE) begin
              break_nxt = 1'b1;
            end else begin
              out_nxt = shift_reg;
              key_nxt = 1'b1;
            end
`else
            out_nxt = shift_reg;
            key_nxt = 1'b1;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      parity_bit      <= 1'b0;
      tmo_cnt         <= '0;
      ps2_out         <= 8'h00;
      ps2_key_pressed <= 1'b0;
      frame_error     <= 1'b0;
      busy            <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending   <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      shift_reg       <= shift_nxt;
      bit_cnt         <= bit_nxt;
      parity_bit      <= parity_nxt;
      tmo_cnt         <= tmo_nxt;
      ps2_out         <= out_nxt;
      ps2_key_pressed <= key_nxt;
      frame_error     <= err_nxt;
      busy            <= (state_nxt != IDLE);
`ifdef PS2_BREAK_FILTER_EN
      break_pending   <= break_nxt;
`endif
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed bench for ps2_rx_frontend. PS/2 bit period is scaled down to
// 40 system clocks to keep the run short; the timeout keeps its default.
module tb_ps2_rx_frontend;
  import ps2_pkg::*;

  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       frame_error;
  logic       busy;
  ps2_state_t debug_state;

  int checks = 0;
  int errors = 0;
  int key_cnt = 0;
  int err_cnt = 0;
  logic both_seen = 1'b0;
  logic busy_at_strobe = 1'b0;
  logic [7:0] exp_q[$];

  ps2_rx_frontend dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .ps2_out         (ps2_out),
    .ps2_key_pressed (ps2_key_pressed),
    .frame_error     (frame_error),
    .busy            (busy),
    .debug_state     (debug_state)
  );

  // Clock/reset block: 100 MHz system clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the head of exp_q.
  always @(posedge clock) begin
    #1;
    if (ps2_key_pressed && frame_error) both_seen = 1'b1;
    if (frame_error) err_cnt++;
    if (ps2_key_pressed) begin
      key_cnt++;
      busy_at_strobe = busy;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("strobe_byte", ps2_out, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ flip_parity);
    send_bit(1'b1);
    ps2_data = 1'b1;
    idle(2 * HALF);
  endtask

  task automatic clear_counts();
    key_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin : main
    logic [7:0] b75;
    int n;
    b75 = 8'h75;

    // Reset state
    reset = 1'b0;
    idle(5);
    check("rst_out", ps2_out, 8'h00);
    check("rst_key", ps2_key_pressed, 0);
    check("rst_err", frame_error, 0);
    check("rst_busy", busy, 0);
    check("rst_state", debug_state, IDLE);
    reset = 1'b1;
    idle(10);

    // Valid 0x1C
    clear_counts();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0);
    check("v1c_keys", key_cnt, 1);
    check("v1c_out", ps2_out, 8'h1C);
    check("v1c_err", err_cnt, 0);
    check("v1c_busy_strobe", busy_at_strobe, 0);
    check("v1c_pending", exp_q.size(), 0);

    // Parity error
    clear_counts();
    send_frame(8'h1C, 1'b1);
    check("par_err", err_cnt, 1);
    check("par_keys", key_cnt, 0);
    check("par_out", ps2_out, 8'h1C);

    // Timeout after start + 4 data bits
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b75[i]);
    ps2_data = 1'b1;
    check("tmo_busy_mid", busy, 1);
    n = 0;
    while (err_cnt == 0 && n < 52000) begin
      @(negedge clock);
      n++;
    end
    check("tmo_window", 32'(n >= 49900 && n <= 50100), 1);
    idle(10);
    check("tmo_err", err_cnt, 1);
    check("tmo_busy", busy, 0);
    check("tmo_keys", key_cnt, 0);

    clear_counts();
    exp_q.push_back(8'h75);
    send_frame(8'h75, 1'b0);
    check("v75_keys", key_cnt, 1);
    check("v75_out", ps2_out, 8'h75);
    check("v75_err", err_cnt, 0);

    // Short glitch on ps2_clk, then 0x6B
    clear_counts();
    @(negedge clock);
    ps2_clk = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    idle(20);
    check("glitch_busy", busy, 0);
    exp_q.push_back(8'h6B);
    send_frame(8'h6B, 1'b0);
    check("g6b_err", err_cnt, 0);
    check("g6b_keys", key_cnt, 1);
    check("g6b_out", ps2_out, 8'h6B);

    // Reset mid-frame after bit 5
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    check("mrst_out", ps2_out, 8'h00);
    check("mrst_busy", busy, 0);
    reset = 1'b1;
    idle(20);
    check("mrst_keys", key_cnt, 0);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0);
    check("mrst_1c_keys", key_cnt, 1);
    check("mrst_1c_out", ps2_out, 8'h1C);

    // Break sequence F0,1C,1C
    clear_counts();
`ifdef PS2_BREAK_FILTER_EN
    exp_q.push_back(8'h1C);
`else
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h1C);
`endif
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
    check("brk_keys", key_cnt, 1);
`else
    check("brk_keys", key_cnt, 3);
`endif
    check("brk_out", ps2_out, 8'h1C);
    check("brk_err", err_cnt, 0);
    check("brk_pending", exp_q.size(), 0);

    check("key_err_exclusive", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
